// File: rtl/io_txn_pkg.sv
// Shared types and sizing helpers for the half-duplex single-wire transaction controller.
package io_txn_pkg;

  // Transaction phases; encoding is fixed so it can be probed from the pad ring.
  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StTx   = 3'd1,
    StTurn = 3'd2,
    StRx   = 3'd3,
    StDone = 3'd4
  } state_e;

  // Default configuration.
  localparam int unsigned DataWDef      = 8;
  localparam int unsigned BitCyclesDef  = 4;
  localparam int unsigned TurnCyclesDef = 2;

  // Bit index must reach DATA_W (room for an optional trailing parity bit).
  function automatic int unsigned idx_width(input int unsigned data_w);
    return $clog2(data_w + 1);
  endfunction

  // Per-bit cycle counter runs 0..BIT_CYCLES-1.
  function automatic int unsigned cnt_width(input int unsigned bit_cycles);
    return (bit_cycles > 1) ? $clog2(bit_cycles) : 1;
  endfunction

  localparam int unsigned IdxW = idx_width(DataWDef);
  localparam int unsigned CntW = cnt_width(BitCyclesDef);

endpackage

// File: rtl/io_bit_timer.sv
// Per-bit cycle timer: free-running 0..BIT_CYCLES-1, restarted on every FSM state entry.
// mid_stb marks the sampling point of a bit, end_stb its last cycle.
module io_bit_timer
  import io_txn_pkg::*;
#(
  parameter int unsigned BIT_CYCLES = BitCyclesDef,
  parameter int unsigned CNT_W      = CntW
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic mid_stb,
  output logic end_stb
);

  localparam logic [CNT_W-1:0] MidCnt = CNT_W'(BIT_CYCLES / 2);
  localparam logic [CNT_W-1:0] EndCnt = CNT_W'(BIT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: restart wins, otherwise wrap at the end of each bit period.
  always_comb begin
    cnt_d = cnt_q;
    if (restart) begin
      cnt_d = '0;
    end else if (cnt_q == EndCnt) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign mid_stb = (cnt_q == MidCnt);
  assign end_stb = (cnt_q == EndCnt);

endmodule

// File: rtl/io_pin_txn_ctrl.sv
// Half-duplex transaction controller for a shared single-wire pin: shifts a command word
// out MSB first, releases the pin for a turnaround gap, then samples a response word.
// The pin is driven only in the TX phase.
// Optional feature macro: IO_PIN_TXN_PARITY_EN appends an even-parity bit to both the TX
// and RX words and adds the parity_err output.
module io_pin_txn_ctrl
  import io_txn_pkg::*;
#(
  parameter int unsigned DATA_W      = DataWDef,
  parameter int unsigned BIT_CYCLES  = BitCyclesDef,
  parameter int unsigned TURN_CYCLES = TurnCyclesDef
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_data,
  output logic [DATA_W-1:0] rx_data,
  output logic              busy,
  output logic              done,
  output logic              io_dir,
`ifdef IO_PIN_TXN_PARITY_EN
  output logic              parity_err,
`endif
  inout  wire               io_pin
);

`ifdef IO_PIN_TXN_PARITY_EN
  localparam int unsigned PAR_W = 1;
`else
  localparam int unsigned PAR_W = 0;
`endif
  // Serial word length on the wire, including the optional parity bit.
  localparam int unsigned NB     = DATA_W + PAR_W;
  localparam int unsigned IDX_W  = idx_width(DATA_W);
  localparam int unsigned CNT_W  = cnt_width(BIT_CYCLES);
  localparam int unsigned TURN_W = $clog2(TURN_CYCLES + 1);

  localparam logic [IDX_W-1:0]  LastIdx  = IDX_W'(NB - 1);
  localparam logic [TURN_W-1:0] LastTurn = TURN_W'(TURN_CYCLES - 1);

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    bit_idx_q, bit_idx_d;
  logic [TURN_W-1:0]   turn_cnt_q, turn_cnt_d;
  logic [NB-1:0]       tx_sh_q, tx_sh_d;
  logic [NB-1:0]       rx_sh_q, rx_sh_d;
  logic [DATA_W-1:0]   rx_data_q, rx_data_d;
  logic [NB-1:0]       tx_load;
  logic                timer_restart;
  logic                mid_stb;
  logic                end_stb;

`ifdef IO_PIN_TXN_PARITY_EN
  // Even parity: appended bit makes the XOR of the whole frame zero.
  assign tx_load = {tx_data, ^tx_data};
`else
  assign tx_load = tx_data;
`endif

  // Every state change restarts the bit timer so each phase begins on count 0.
  assign timer_restart = (state_d != state_q);

  io_bit_timer #(
    .BIT_CYCLES (BIT_CYCLES),
    .CNT_W      (CNT_W)
  ) u_bit_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (timer_restart),
    .mid_stb (mid_stb),
    .end_stb (end_stb)
  );

  // FSM next state plus shift-register / bit-index / turnaround-counter updates.
  always_comb begin
    state_d    = state_q;
    bit_idx_d  = bit_idx_q;
    turn_cnt_d = turn_cnt_q;
    tx_sh_d    = tx_sh_q;
    rx_sh_d    = rx_sh_q;
    rx_data_d  = rx_data_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d   = StTx;
          tx_sh_d   = tx_load;
          rx_sh_d   = '0;
          bit_idx_d = '0;
        end
      end

      StTx: begin
        if (end_stb) begin
          tx_sh_d = tx_sh_q << 1;
          if (bit_idx_q == LastIdx) begin
            state_d    = StTurn;
            bit_idx_d  = '0;
            turn_cnt_d = '0;
          end else begin
            bit_idx_d = bit_idx_q + IDX_W'(1);
          end
        end
      end

      // Pin released and ignored; only counts off the gap.
      StTurn: begin
        if (turn_cnt_q == LastTurn) begin
          state_d = StRx;
        end else begin
          turn_cnt_d = turn_cnt_q + TURN_W'(1);
        end
      end

      StRx: begin
        if (mid_stb) begin
          rx_sh_d = {rx_sh_q[NB-2:0], io_pin};
        end
        if (end_stb) begin
          if (bit_idx_q == LastIdx) begin
            state_d   = StDone;
            // Use rx_sh_d so a sample landing on the final cycle is not lost.
            rx_data_d = rx_sh_d[NB-1 -: DATA_W];
          end else begin
            bit_idx_d = bit_idx_q + IDX_W'(1);
          end
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers; reset aborts any transaction and releases the pin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      bit_idx_q  <= '0;
      turn_cnt_q <= '0;
      tx_sh_q    <= '0;
      rx_sh_q    <= '0;
      rx_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      bit_idx_q  <= bit_idx_d;
      turn_cnt_q <= turn_cnt_d;
      tx_sh_q    <= tx_sh_d;
      rx_sh_q    <= rx_sh_d;
      rx_data_q  <= rx_data_d;
    end
  end

`ifdef IO_PIN_TXN_PARITY_EN
  logic parity_err_q, parity_err_d;

  // Parity flag: cleared on accept, loaded with the frame parity check on entry to DONE.
  always_comb begin
    parity_err_d = parity_err_q;
    if ((state_q == StIdle) && start) begin
      parity_err_d = 1'b0;
    end else if ((state_q == StRx) && (state_d == StDone)) begin
      parity_err_d = ^rx_sh_d;
    end
  end

  // Parity flag register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_err_q <= 1'b0;
    end else begin
      parity_err_q <= parity_err_d;
    end
  end

  assign parity_err = parity_err_q;
`endif

  assign busy    = (state_q != StIdle);
  assign done    = (state_q == StDone);
  assign io_dir  = (state_q == StTx);
  assign rx_data = rx_data_q;

  // Drive only in TX; every other state leaves the wire to the far end.
  assign io_pin = io_dir ? tx_sh_q[NB-1] : 1'bz;

endmodule

// File: tb/tb_io_pin_txn_ctrl.sv
// Self-checking bench for io_pin_txn_ctrl (DATA_W=8, BIT_CYCLES=4, TURN_CYCLES=2).
// A transaction-level model predicts every output from the cycle offset since accept;
// directed tests add hand-computed literal expectations.
`timescale 1ns/1ps
module tb_io_pin_txn_ctrl;

  localparam int DW = 8;
  localparam int BC = 4;
  localparam int TC = 2;
`ifdef IO_PIN_TXN_PARITY_EN
  localparam int PW = 1;
`else
  localparam int PW = 0;
`endif
  localparam int NB       = DW + PW;
  localparam int NTX      = NB * BC;
  localparam int NRX      = NB * BC;
  localparam int DONE_OFF = 1 + NTX + TC + NRX;

  // Hand-computed literals.
`ifdef IO_PIN_TXN_PARITY_EN
  localparam int EXP_LAT = 75;
  localparam int EXP_GAP = 76;
  localparam int CAP_A5  = 'h14A;
  localparam int CAP_96  = 'h12C;
  localparam int CAP_0F  = 'h01E;
`else
  localparam int EXP_LAT = 67;
  localparam int EXP_GAP = 68;
  localparam int CAP_A5  = 'hA5;
  localparam int CAP_96  = 'h96;
  localparam int CAP_0F  = 'h0F;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic [7:0] tx_data = 8'h00;
  wire  [7:0] rx_data;
  wire        busy;
  wire        done;
  wire        io_dir;
  wire        io_pin;
`ifdef IO_PIN_TXN_PARITY_EN
  wire        parity_err;
`endif

  io_pin_txn_ctrl #(
    .DATA_W      (DW),
    .BIT_CYCLES  (BC),
    .TURN_CYCLES (TC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .tx_data    (tx_data),
    .rx_data    (rx_data),
    .busy       (busy),
    .done       (done),
    .io_dir     (io_dir),
`ifdef IO_PIN_TXN_PARITY_EN
    .parity_err (parity_err),
`endif
    .io_pin     (io_pin)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [NB-1:0] mk_bits(input logic [7:0] w, input logic p);
`ifdef IO_PIN_TXN_PARITY_EN
    return {w, p};
`else
    return (p === 1'bx) ? w : w;
`endif
  endfunction

  // ---------------- transaction model ----------------
  logic          m_act = 1'b0;
  int            m_t = 0;
  logic [NB-1:0] m_tbits = '0;
  logic [NB-1:0] m_rbits = '0;
  logic [7:0]    m_rx = 8'h00;
  logic          m_perr = 1'b0;
  logic [7:0]    resp_cfg = 8'h00;
  logic          resp_par_cfg = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_act  <= 1'b0;
      m_t    <= 0;
      m_rx   <= 8'h00;
      m_perr <= 1'b0;
    end else if (!m_act) begin
      if (start) begin
        m_act   <= 1'b1;
        m_t     <= 1;
        m_tbits <= mk_bits(tx_data, ^tx_data);
        m_rbits <= mk_bits(resp_cfg, resp_par_cfg);
        m_perr  <= 1'b0;
      end
    end else if (m_t == DONE_OFF) begin
      m_act <= 1'b0;
      m_t   <= 0;
    end else begin
      m_t <= m_t + 1;
      if (m_t + 1 == DONE_OFF) begin
        m_rx   <= m_rbits[NB-1 -: DW];
        m_perr <= ^m_rbits;
      end
    end
  end

  // Far-end driver: junk during the turnaround gap, then the response frame.
  logic drv_en;
  logic drv_val;
  always_comb begin
    drv_en  = 1'b0;
    drv_val = 1'b0;
    if (m_act && m_t > NTX && m_t <= NTX + TC) begin
      drv_en  = 1'b1;
      drv_val = 1'b1;
    end else if (m_act && m_t > NTX + TC && m_t < DONE_OFF) begin
      drv_en  = 1'b1;
      drv_val = m_rbits[NB - 1 - ((m_t - NTX - TC - 1) / BC)];
    end
  end
  assign io_pin = drv_en ? drv_val : 1'bz;

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    automatic logic e_dir  = m_act && (m_t >= 1) && (m_t <= NTX);
    automatic logic e_done = m_act && (m_t == DONE_OFF);
    chk("io_dir", int'(io_dir), int'(e_dir));
    chk("busy", int'(busy), int'(m_act));
    chk("done", int'(done), int'(e_done));
    if (e_dir) chk("io_pin", int'(io_pin), int'(m_tbits[NB - 1 - ((m_t - 1) / BC)]));
    if (!m_act || e_done) chk("rx_data", int'(rx_data), int'(m_rx));
`ifdef IO_PIN_TXN_PARITY_EN
    chk("parity_err", int'(parity_err), int'(m_perr));
`endif
  end

  // ---------------- directed stimulus ----------------
  int            acc_cyc;
  int            lat;
  int            ndone;
  int            busy_after;
  logic [NB-1:0] cap;
  logic          perr_cap;

  task automatic launch(input logic [7:0] tx, input logic [7:0] resp, input logic rpar);
    @(negedge clk);
    tx_data      = tx;
    resp_cfg     = resp;
    resp_par_cfg = rpar;
    start        = 1'b1;
    @(posedge clk);
    #1 acc_cyc = cyc;
  endtask

  // Follow one transaction; optional one-cycle start pulses at a given offset and at DONE.
  task automatic watch(input int pulse_at, input bit pulse_done);
    int off;
    bit grab;
    lat = -1; ndone = 0; busy_after = -1; cap = '0; perr_cap = 1'b0; grab = 1'b0;
    for (int i = 0; i < DONE_OFF + 10; i++) begin
      @(negedge clk);
      off = cyc - acc_cyc + 1;
      if (grab) begin
        busy_after = int'(busy);
        grab = 1'b0;
      end
      if (io_dir && off >= 1 && ((off - 1) % BC) == BC / 2) cap = {cap[NB-2:0], io_pin};
      if (done) begin
        ndone++;
`ifdef IO_PIN_TXN_PARITY_EN
        perr_cap = parity_err;
`endif
        if (lat < 0) begin
          lat  = off;
          grab = 1'b1;
        end
      end
      start   = ((pulse_at > 0) && (off == pulse_at)) || (pulse_done && done);
      tx_data = 8'(i * 37);
    end
    start = 1'b0;
  endtask

  initial begin
    int first_done;
    int second_done;
    int idle_cnt;
    int off;

    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_io_dir", int'(io_dir), 0);
    chk("rst_rx_data", int'(rx_data), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Basic transaction: A5 out, 3C back.
    launch(8'hA5, 8'h3C, 1'b0);
    watch(0, 1'b0);
    chk("basic_latency", lat, EXP_LAT);
    chk("basic_tx_bits", int'(cap), CAP_A5);
    chk("basic_rx_data", int'(rx_data), 'h3C);
    chk("basic_busy_after_done", busy_after, 0);
    chk("basic_done_count", ndone, 1);

    // start pulses mid-TX and on the DONE cycle are ignored.
    launch(8'h96, 8'h5B, 1'b1);
    watch(10, 1'b1);
    chk("ignore_done_count", ndone, 1);
    chk("ignore_tx_bits", int'(cap), CAP_96);
    chk("ignore_latency", lat, EXP_LAT);
    chk("ignore_rx_data", int'(rx_data), 'h5B);
    chk("ignore_idle_busy", int'(busy), 0);

    // Reset mid-TX aborts immediately.
    launch(8'hC3, 8'h77, 1'b0);
    off = 0;
    for (int i = 0; i < 40 && off < 20; i++) begin
      @(negedge clk);
      start = 1'b0;
      off = cyc - acc_cyc + 1;
    end
    chk("abort_reached_tx", int'(io_dir), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_io_dir", int'(io_dir), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_rx_data", int'(rx_data), 0);
    repeat (2) @(negedge clk);
    chk("abort_no_done", int'(done), 0);
    rst_n = 1'b1;
    launch(8'h0F, 8'hE1, 1'b0);
    watch(0, 1'b0);
    chk("post_abort_latency", lat, EXP_LAT);
    chk("post_abort_tx_bits", int'(cap), CAP_0F);
    chk("post_abort_rx_data", int'(rx_data), 'hE1);

    // start held high: back-to-back transactions with one IDLE cycle between.
    @(negedge clk);
    tx_data = 8'hFF; resp_cfg = 8'h00; resp_par_cfg = 1'b0; start = 1'b1;
    first_done = -1; second_done = -1; idle_cnt = 0;
    for (int i = 0; i < 3 * DONE_OFF; i++) begin
      @(negedge clk);
      if (done) begin
        if (first_done < 0) first_done = cyc;
        else begin
          second_done = cyc;
          start = 1'b0;
          break;
        end
      end else if (first_done >= 0 && !busy) begin
        idle_cnt++;
      end
    end
    start = 1'b0;
    chk("b2b_gap", second_done - first_done, EXP_GAP);
    chk("b2b_idle_cycles", idle_cnt, 1);
    repeat (3) @(negedge clk);
    chk("b2b_rx_data", int'(rx_data), 0);
    chk("b2b_no_retrigger", int'(busy), 0);

`ifdef IO_PIN_TXN_PARITY_EN
    // Wrong parity on the response: 3C has even weight, parity bit 1 is an error.
    launch(8'hA5, 8'h3C, 1'b1);
    watch(0, 1'b0);
    chk("par_latency", lat, 75);
    chk("par_tx_bits", int'(cap), 'h14A);
    chk("par_err_with_done", int'(perr_cap), 1);
    chk("par_rx_data", int'(rx_data), 'h3C);
`endif

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
